// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte sources.
// Latches the winner's byte, pulses tx_start/ack, then tracks the frame to done or err.
module uart_tx_scheduler #(
   parameter int NUM_REQ  = 2,
   parameter int DATA_W   = 8,
   parameter int START_TO = 16
) (
   input  logic                       MAX10_CLK1_50,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic                       tx_start,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       tx_busy,
   input  logic                       tx_done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(START_TO + 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t        state, state_nx;
   logic [IW-1:0] last, last_nx;
   logic [IW-1:0] win;
   logic          found;
   logic [CW-1:0] cnt, cnt_nx;
   logic          done_nx, err_nx;
   int            idx;

   // Scan starts just after the last completed grant, wrapping modulo NUM_REQ.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
   end

   always_comb begin
      state_nx = state;
      last_nx  = last;
      cnt_nx   = cnt;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) state_nx = START;
         end
         START: begin
            cnt_nx   = '0;
            state_nx = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_done) begin
               done_nx  = 1'b1;
               last_nx  = grant_id;
               state_nx = IDLE;
            end else if (tx_busy) begin
               state_nx = WAIT_DONE;
            end else if (cnt == CW'(START_TO - 1)) begin
               // A timed-out source keeps its priority position.
               err_nx   = 1'b1;
               state_nx = IDLE;
            end else if (cnt != {CW{1'b1}}) begin
               cnt_nx = cnt + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (tx_done) begin
               done_nx  = 1'b1;
               last_nx  = grant_id;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         last     <= IW'(NUM_REQ - 1);
         cnt      <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         grant_id <= '0;
         tx_data  <= '0;
      end else begin
         state <= state_nx;
         last  <= last_nx;
         cnt   <= cnt_nx;
         done  <= done_nx;
         err   <= err_nx;
         if (state == IDLE && found) begin
            grant_id <= win;
            tx_data  <= req_data[int'(win)*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      ack = '0;
      if (state == START) ack[grant_id] = 1'b1;
   end

   assign tx_start = (state == START);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
// Bench for uart_tx_scheduler: vector table, corner sequences and random
// traffic checked against a transaction-level round-robin model.
module tb_uart_tx_scheduler;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic [1:0] req      = '0;
   logic [15:0] req_data = '0;
   logic       tx_busy  = 1'b0;
   logic       tx_done  = 1'b0;
   logic [1:0] ack;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [0:0] grant_id;
   logic       busy, done, err;

   int errors = 0;
   int checks = 0;

   // Transmitter model: 0 busy tx_len cycles then done, 1 done only, 2 ignore.
   int tx_mode = 0;
   int tx_len  = 4;
   int tx_ctr  = 0;
   bit tx_on   = 1'b0;
   bit start_seen   = 1'b0;
   bit prev_tx_done = 1'b0;

   typedef struct {
      logic [1:0] r;
      logic [7:0] d0;
      logic [7:0] d1;
      int         g;
      logic [7:0] data;
   } vec_t;

   vec_t vecs[7];

   always #10 clk = ~clk;

   uart_tx_scheduler #(
      .NUM_REQ(2),
      .DATA_W(8),
      .START_TO(16)
   ) dut (
      .MAX10_CLK1_50(clk),
      .rst(rst),
      .req(req),
      .req_data(req_data),
      .ack(ack),
      .tx_start(tx_start),
      .tx_data(tx_data),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .grant_id(grant_id),
      .busy(busy),
      .done(done),
      .err(err)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      prev_tx_done = tx_done;
      if (start_seen) begin
         tx_on  = 1'b1;
         tx_ctr = 0;
      end else if (tx_on) begin
         tx_ctr++;
      end
      tx_busy = 1'b0;
      tx_done = 1'b0;
      if (tx_on) begin
         case (tx_mode)
            0: begin
               if (tx_ctr < tx_len) tx_busy = 1'b1;
               else begin
                  tx_done = 1'b1;
                  tx_on   = 1'b0;
               end
            end
            1: begin
               if (tx_ctr == tx_len - 1) begin
                  tx_done = 1'b1;
                  tx_on   = 1'b0;
               end
            end
            default: tx_on = 1'b0;
         endcase
      end
      start_seen = tx_start;
   endtask

   task automatic apply_reset(input string name);
      req = '0;
      tx_on = 1'b0;
      start_seen = 1'b0;
      tx_busy = 1'b0;
      tx_done = 1'b0;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk({name, "_rst_tx_start"}, tx_start, 0);
      chk({name, "_rst_ack"}, ack, 0);
      chk({name, "_rst_tx_data"}, tx_data, 0);
      chk({name, "_rst_grant"}, grant_id, 0);
      chk({name, "_rst_busy"}, busy, 0);
      chk({name, "_rst_done"}, done, 0);
      chk({name, "_rst_err"}, err, 0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen = 1'b0;
      bit any_err = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (err) any_err = 1'b1;
         if (done) begin
            seen = 1'b1;
            chk({name, "_done_lat"}, prev_tx_done, 1);
            chk({name, "_idle"}, busy, 0);
         end
      end
      chk({name, "_done_seen"}, seen, 1);
      chk({name, "_no_err"}, any_err, 0);
   endtask

   task automatic wait_start(input string name, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (tx_start) seen = 1'b1;
      end
      chk({name, "_start_seen"}, seen, 1);
   endtask

   task automatic run_frame(input string name, input logic [1:0] r,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input int g, input logic [7:0] data);
      logic [1:0] ea;
      ea = 2'b01 << g;
      req_data = {d1, d0};
      req = r;
      tick();
      chk({name, "_tx_start"}, tx_start, 1);
      chk({name, "_ack"}, ack, ea);
      chk({name, "_grant"}, grant_id, g);
      chk({name, "_tx_data"}, tx_data, data);
      req = '0;
      wait_done(name, 40);
   endtask

   function automatic int rr(input logic [1:0] r, input int lst);
      for (int k = 1; k <= 2; k++)
         if (r[(lst + k) % 2]) return (lst + k) % 2;
      return -1;
   endfunction

   initial begin
      int n;
      int m_ph, m_last, m_win;
      bit exp_start, exp_done;
      logic [1:0] exp_ack;
      logic [7:0] exp_byte;
      logic [7:0] src_byte[2];

      vecs[0] = '{2'b01, 8'h55, 8'h00, 0, 8'h55};
      vecs[1] = '{2'b11, 8'hA5, 8'h3C, 1, 8'h3C};
      vecs[2] = '{2'b11, 8'h12, 8'h34, 0, 8'h12};
      vecs[3] = '{2'b01, 8'hC3, 8'hFF, 0, 8'hC3};
      vecs[4] = '{2'b10, 8'h00, 8'hE7, 1, 8'hE7};
      vecs[5] = '{2'b10, 8'h80, 8'h01, 1, 8'h01};
      vecs[6] = '{2'b11, 8'hFE, 8'h7F, 0, 8'hFE};

      apply_reset("tab");
      tx_mode = 0;
      tx_len  = 4;
      foreach (vecs[i])
         run_frame($sformatf("vec%0d", i), vecs[i].r, vecs[i].d0,
                   vecs[i].d1, vecs[i].g, vecs[i].data);

      // Single source, long frame.
      apply_reset("t1");
      tx_mode = 0;
      tx_len  = 10;
      run_frame("t1", 2'b01, 8'h55, 8'h00, 0, 8'h55);

      // Tie from reset, each source drops its request on ack.
      apply_reset("t2");
      tx_len = 4;
      req_data = {8'h3C, 8'hA5};
      req = 2'b11;
      wait_start("t2a", 5);
      chk("t2a_grant", grant_id, 0);
      chk("t2a_ack", ack, 2'b01);
      chk("t2a_data", tx_data, 8'hA5);
      req = 2'b10;
      wait_done("t2a", 30);
      wait_start("t2b", 5);
      chk("t2b_grant", grant_id, 1);
      chk("t2b_ack", ack, 2'b10);
      chk("t2b_data", tx_data, 8'h3C);
      req = 2'b00;
      wait_done("t2b", 30);

      // Continuous tie alternates.
      apply_reset("t3");
      tx_len = 2;
      req_data = {8'h22, 8'h11};
      req = 2'b11;
      for (int i = 0; i < 6; i++) begin
         wait_start($sformatf("t3_%0d", i), 5);
         chk($sformatf("t3_%0d_grant", i), grant_id, i % 2);
         wait_done($sformatf("t3_%0d", i), 20);
      end
      req = 2'b00;

      // Transmitter ignores tx_start.
      apply_reset("t4");
      tx_mode = 2;
      req_data = {8'h00, 8'h77};
      req = 2'b01;
      wait_start("t4", 5);
      req = 2'b00;
      n = 0;
      for (int i = 0; i < 30 && !err; i++) begin
         tick();
         n++;
      end
      chk("t4_err_cycle", n, 17);
      chk("t4_err_busy", busy, 0);
      chk("t4_err_done", done, 0);
      tick();
      chk("t4_err_pulse", err, 0);
      tx_mode = 0;
      tx_len  = 3;
      run_frame("t4_tie", 2'b11, 8'h11, 8'h22, 0, 8'h11);

      // Reset during WAIT_DONE.
      apply_reset("t5");
      tx_mode = 0;
      tx_len  = 10;
      run_frame("t5a", 2'b01, 8'h5A, 8'h99, 0, 8'h5A);
      req_data = {8'h99, 8'h5A};
      req = 2'b10;
      tick();
      chk("t5b_start", tx_start, 1);
      chk("t5b_grant", grant_id, 1);
      req = 2'b00;
      tick();
      tick();
      tick();
      chk("t5b_in_frame", busy, 1);
      apply_reset("t5_mid");
      tx_len = 3;
      run_frame("t5_ptr", 2'b11, 8'h01, 8'h02, 0, 8'h01);
      run_frame("t5_src1", 2'b10, 8'h03, 8'h04, 1, 8'h04);

      // Transmitter pulses done without busy.
      apply_reset("t6");
      tx_mode = 1;
      tx_len  = 3;
      run_frame("t6", 2'b01, 8'h6B, 8'h00, 0, 8'h6B);

      // Random traffic against the transaction model.
      apply_reset("rnd");
      tx_mode = 0;
      tx_len  = 3;
      m_ph = 0;
      m_last = 1;
      m_win = 0;
      exp_start = 1'b0;
      exp_done = 1'b0;
      exp_ack = '0;
      exp_byte = '0;
      src_byte[0] = '0;
      src_byte[1] = '0;
      for (int c = 0; c < 600; c++) begin
         tick();
         chk("rnd_start", tx_start, exp_start);
         chk("rnd_ack", ack, exp_ack);
         chk("rnd_done", done, exp_done);
         chk("rnd_err", err, 0);
         if (exp_start) begin
            chk("rnd_grant", grant_id, m_win);
            chk("rnd_data", tx_data, exp_byte);
         end
         if (tx_start) begin
            tx_mode = int'($urandom_range(0, 1));
            tx_len  = int'($urandom_range(1, 6));
         end
         for (int i = 0; i < 2; i++) begin
            if (ack[i]) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               src_byte[i] = 8'($urandom);
            end
         end
         req_data = {src_byte[1], src_byte[0]};
         exp_start = 1'b0;
         exp_done  = 1'b0;
         exp_ack   = '0;
         case (m_ph)
            0: if (|req) begin
               m_win = rr(req, m_last);
               exp_start = 1'b1;
               exp_ack = 2'b01 << m_win;
               exp_byte = src_byte[m_win];
               m_ph = 1;
            end
            1: m_ph = 2;
            default: if (tx_done) begin
               exp_done = 1'b1;
               m_last = m_win;
               m_ph = 0;
            end
         endcase
      end
      req = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
